pipe_ctrl: RTL
==============

Name: pipe_ctrl

Overview:
Central pipeline controller for the five-stage MIPS core. It merges per-stage stall requests into the 6-bit stall vector consumed by every pipeline register (pc, if_id, id_ex, ex_mem, mem_wb), and sequences the exception flush. It also keeps stall statistics and a stall watchdog. It sits beside the pipeline and is driven by the stage stall requests and the mem-stage exception type from CP0 logic.

Parameters:
EXC_VECTOR, 32'h00000020, handler entry address for all non-ERET exceptions.
STALL_LIMIT, 1024, consecutive stalled cycles that trip the watchdog (≥2).
WDOG_W, 16, watchdog counter width; STALL_LIMIT < 2^WDOG_W.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset (asserted when 0)
stallreq_from_if  input  1  instruction bus not ready
stallreq_from_id  input  1  load-use / branch hazard in id
stallreq_from_ex  input  1  multi-cycle ex op (mult/div/madd) busy
stallreq_from_mem  input  1  data bus not ready
excepttype  input  32  final exception type from mem stage; 0 = none
cp0_epc  input  32  current EPC, used for ERET
stall  output  6  [0]=pc [1]=if [2]=id [3]=ex [4]=mem [5]=wb; 1 = stop
flush  output  1  clear all pipeline registers, pc loads new_pc
new_pc  output  32  redirect target, valid while flush=1
stall_timeout  output  1  one-cycle pulse when watchdog trips
stall_cycles  output  32  total cycles with stall != 0 since reset

Behaviour:
- Reset (rst=0, async): state=RUN, flush=0, new_pc=0, stall_timeout=0, stall_cycles=0, watchdog=0. stall forced to 6'b000000 while rst=0.
- States: RUN, FLUSH. flush and new_pc are registered (Moore). stall is combinational from inputs and state.
- RUN stall encoding, fixed priority mem > ex > id > if:
  - stallreq_from_mem → 6'b011111
  - else stallreq_from_ex → 6'b001111
  - else stallreq_from_id → 6'b000111
  - else stallreq_from_if → 6'b000011
  - else 6'b000000
- Exception take (RUN, excepttype≠0, stallreq_from_mem=0):
  - That cycle stall=6'b111111 (freeze all).
  - new_pc latched: cp0_epc if excepttype==32'h0000000e (ERET), else EXC_VECTOR.
  - Next state FLUSH.
- Exception while stallreq_from_mem=1: not taken. stall=6'b011111, state stays RUN, and the exception is re-evaluated every cycle until mem ready.
- FLUSH (exactly 1 cycle):
  - flush=1, stall=6'b000000, all stall requests and excepttype ignored.
  - Next state RUN; flush returns to 0, new_pc holds its value.
- stall_cycles: +1 every cycle the stall output is non-zero, including the freeze cycle. It wraps at 2^32 with no saturation.
- Watchdog:
  - Counts consecutive cycles with stall≠0; cleared by any cycle with stall=0 or by FLUSH.
  - When the count reaches STALL_LIMIT−1 and stall≠0, stall_timeout pulses for 1 cycle (registered) and the counter clears, so it re-arms.
  - Stall behaviour is not altered by the watchdog.
- Reset mid-FLUSH: flush drops immediately (async); state RUN after reset release.

Test Plan:
- stallreq_from_ex=1, others 0 for 3 cycles → stall=6'b001111 each cycle; stall_cycles 0→3; flush=0.
- mem=1 and id=1 together → stall=6'b011111. Drop mem → stall=6'b000111 same cycle.
- excepttype=32'h00000008 one cycle, no stalls → that cycle stall=6'b111111; next cycle flush=1, new_pc=32'h00000020, stall=0; cycle after, flush=0.
- excepttype=32'h0000000e, cp0_epc=32'hbfc00100, stallreq_from_mem=1 for 2 cycles then 0 → 2 cycles stall=6'b011111, then 6'b111111, then flush=1 with new_pc=32'hbfc00100.
- STALL_LIMIT=4, stallreq_from_if held 9 cycles → stall_timeout pulses on the 4th and 8th stalled cycle edges; a one-cycle gap in the request resets the count.
- rst pulled low during FLUSH cycle → flush=0, stall=0, stall_cycles=0 immediately. After release, a 2-cycle id stall → stall_cycles=2.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// Stall-request / flush bundle between the pipeline stages and pipe_ctrl.
interface pipe_ctrl_if;
   logic        stallreq_from_if;
   logic        stallreq_from_id;
   logic        stallreq_from_ex;
   logic        stallreq_from_mem;
   logic [31:0] excepttype;
   logic [31:0] cp0_epc;
   logic [5:0]  stall;
   logic        flush;
   logic [31:0] new_pc;
   logic        stall_timeout;
   logic [31:0] stall_cycles;

   // Pipeline side: raises requests, consumes stall/flush
   modport master (
      output stallreq_from_if, stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
      output excepttype, cp0_epc,
      input  stall, flush, new_pc, stall_timeout, stall_cycles
   );

   // Controller side
   modport slave (
      input  stallreq_from_if, stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
      input  excepttype, cp0_epc,
      output stall, flush, new_pc, stall_timeout, stall_cycles
   );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline stall merger, exception flush sequencer, stall statistics and stall watchdog.
module pipe_ctrl #(
   parameter logic [31:0] EXC_VECTOR  = 32'h00000020,
   parameter int unsigned STALL_LIMIT = 1024,
   parameter int unsigned WDOG_W      = 16
) (
   input logic        clk,
   input logic        rst,
   pipe_ctrl_if.slave bus
);
   localparam int unsigned SW = 6;
   localparam logic [31:0] ERET_CODE = 32'h0000000e;
   localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(STALL_LIMIT - 1);

   typedef enum logic {RUN, FLUSH} state_t;

   state_t            r_state;
   logic              r_flush;
   logic [31:0]       r_new_pc;
   logic              r_timeout;
   logic [31:0]       r_stall_cycles;
   logic [WDOG_W-1:0] r_wdog;

   logic [SW-1:0]     w_stall;
   logic              w_exc;
   logic              w_take;

   assign w_exc  = (bus.excepttype != 32'd0);
   assign w_take = (r_state == RUN) && w_exc && !bus.stallreq_from_mem;

   // Stall vector: mem holds off exception take; a taken exception freezes all stages
   always_comb begin
      w_stall = SW'(6'b000000);
      if (!rst || r_state == FLUSH)  w_stall = SW'(6'b000000);
      else if (bus.stallreq_from_mem) w_stall = SW'(6'b011111);
      else if (w_exc)                 w_stall = SW'(6'b111111);
      else if (bus.stallreq_from_ex)  w_stall = SW'(6'b001111);
      else if (bus.stallreq_from_id)  w_stall = SW'(6'b000111);
      else if (bus.stallreq_from_if)  w_stall = SW'(6'b000011);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state        <= RUN;
         r_flush        <= 1'b0;
         r_new_pc       <= 32'd0;
         r_timeout      <= 1'b0;
         r_stall_cycles <= 32'd0;
         r_wdog         <= '0;
      end else begin
         r_timeout <= 1'b0;
         case (r_state)
            RUN: begin
               if (w_take) begin
                  r_state  <= FLUSH;
                  r_flush  <= 1'b1;
                  r_new_pc <= (bus.excepttype == ERET_CODE) ? bus.cp0_epc : EXC_VECTOR;
               end
            end
            FLUSH: begin
               r_state <= RUN;
               r_flush <= 1'b0;
            end
            default: begin
               r_state <= RUN;
               r_flush <= 1'b0;
            end
         endcase

         if (w_stall != SW'(0)) r_stall_cycles <= r_stall_cycles + 32'd1;

         // Watchdog re-arms itself after every trip
         if (r_state == FLUSH || w_stall == SW'(0)) begin
            r_wdog <= '0;
         end else if (r_wdog == WDOG_LAST) begin
            r_wdog    <= '0;
            r_timeout <= 1'b1;
         end else begin
            r_wdog <= r_wdog + WDOG_W'(1);
         end
      end
   end

   assign bus.stall         = w_stall;
   assign bus.flush         = r_flush;
   assign bus.new_pc        = r_new_pc;
   assign bus.stall_timeout = r_timeout;
   assign bus.stall_cycles  = r_stall_cycles;
endmodule
